// File: rtl/axi_lite_mem_pattern_checker_if.sv
// AXI4-Lite channel bundle between the pattern checker (master) and a memory slave.
interface axi_lite_mem_pattern_checker_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_mem_pattern_checker.sv
// Self-checking AXI4-Lite master: writes SEED^i to NUM_WORDS words, reads them back,
// counts data mismatches and non-OKAY responses.
module axi_lite_mem_pattern_checker #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    NUM_WORDS  = 16,
  parameter logic [31:0]           SEED       = 32'hA5A5_0000
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  axi_lite_mem_pattern_checker_if.master axi
);
  localparam int          BYTES = DATA_WIDTH / 8;
  localparam logic [15:0] LAST  = 16'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t                  state, state_n;
  logic [15:0]             idx;
  logic                    aw_done, w_done;
  logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [15:0] i);
    return BASE_ADDR + ADDR_WIDTH'(i) * ADDR_WIDTH'(BYTES);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [15:0] i);
    return DATA_WIDTH'(SEED) ^ DATA_WIDTH'(i);
  endfunction

  logic aw_hs, w_hs, start_ok, last, b_fire, r_fire, rd_err;
  logic [15:0] idx_inc;

  assign aw_hs    = axi.AWVALID & axi.AWREADY;
  assign w_hs     = axi.WVALID & axi.WREADY;
  assign start_ok = start & ((state == IDLE) | (state == DONE));
  assign last     = (idx == LAST);
  assign idx_inc  = idx + 16'd1;
  assign b_fire   = (state == WR_RESP) & axi.BVALID;
  assign r_fire   = (state == RD_RESP) & axi.RVALID;
  // Data and response faults on the same beat are one error, not two.
  assign rd_err   = (axi.RDATA != pattern(idx)) | (axi.RRESP != 2'b00);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: if (start) state_n = WR_REQ;
      WR_REQ:     if ((aw_done | aw_hs) & (w_done | w_hs)) state_n = WR_RESP;
      WR_RESP:    if (axi.BVALID) state_n = last ? RD_REQ : WR_REQ;
      RD_REQ:     if (axi.ARREADY) state_n = RD_RESP;
      RD_RESP:    if (axi.RVALID) state_n = last ? DONE : RD_REQ;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      idx       <= '0;
      err_count <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (start_ok) begin
        idx       <= '0;
        err_count <= '0;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
        awaddr_q  <= addr_of(16'd0);
        wdata_q   <= pattern(16'd0);
      end
      if (b_fire) begin
        if (axi.BRESP != 2'b00 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (last) begin
          idx      <= '0;
          araddr_q <= addr_of(16'd0);
        end else begin
          idx      <= idx_inc;
          awaddr_q <= addr_of(idx_inc);
          wdata_q  <= pattern(idx_inc);
        end
      end
      if (r_fire) begin
        if (rd_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (!last) begin
          idx      <= idx_inc;
          araddr_q <= addr_of(idx_inc);
        end
      end
    end
  end

  // Each write channel drops its VALID independently once its own handshake is seen.
  assign axi.AWVALID = (state == WR_REQ) & ~aw_done;
  assign axi.WVALID  = (state == WR_REQ) & ~w_done;
  assign axi.AWADDR  = awaddr_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = '1;
  assign axi.BREADY  = (state == WR_RESP);
  assign axi.ARVALID = (state == RD_REQ);
  assign axi.ARADDR  = araddr_q;
  assign axi.RREADY  = (state == RD_RESP);

  assign done = (state == DONE);
  assign busy = (state != IDLE) & (state != DONE);
  assign pass = done & (err_count == 16'd0);
endmodule

// File: tb/tb_axi_lite_mem_pattern_checker.sv
// Bench for axi_lite_mem_pattern_checker: configurable memory slave, reference model of
// the expected transaction stream and error total, per-cycle compare process.
module tb_axi_lite_mem_pattern_checker;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NW   = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_count;

  axi_lite_mem_pattern_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_mem_pattern_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .NUM_WORDS(NW), .SEED(SEED)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .axi(bus)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: word i lives at BASE + 4*i (mod 2^32) and holds SEED ^ i.
  function automatic logic [31:0] m_addr(input int i);
    logic [63:0] a;
    a = 64'(BASE) + 64'(i) * 64'd4;
    return a[31:0];
  endfunction

  function automatic logic [31:0] m_pat(input int i);
    return SEED ^ 32'(i);
  endfunction

  // slave configuration: index of faulty beat per run, -1 = none
  int cfg_bwr = -1, cfg_brd = -1, cfg_brr = -1, cfg_awd = 0;
  int sl_wr = 0, sl_rd = 0;
  logic [31:0] mem [logic [31:0]];

  // model / scoreboard state
  int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0, exp_err = 0;
  bit seen_w_first = 0;
  logic [31:0] aw_log [$];

  // Slave: decides READY/VALID at negedge, observes handshakes on the following negedge.
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w;
    logic [31:0] a_aw, d_w, a_ar;
    int aw_wait;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; got_aw = 0; got_w = 0;
    a_aw = 0; d_w = 0; a_ar = 0; aw_wait = 0;
    bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
    bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; got_aw = 0; got_w = 0; aw_wait = 0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
        bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0;
        continue;
      end
      if (b_hs) bus.BVALID = 0;
      if (r_hs) bus.RVALID = 0;
      if (aw_hs) got_aw = 1;
      if (w_hs) got_w = 1;
      if (ar_hs) begin
        bus.RDATA = mem.exists(a_ar) ? mem[a_ar] : 32'h0;
        if (sl_rd == cfg_brd) bus.RDATA[0] = ~bus.RDATA[0];
        bus.RRESP = (sl_rd == cfg_brr) ? 2'b10 : 2'b00;
        bus.RVALID = 1;
        sl_rd++;
      end
      if (got_aw && got_w && !bus.BVALID) begin
        mem[a_aw] = d_w;
        bus.BRESP = (sl_wr == cfg_bwr) ? 2'b10 : 2'b00;
        bus.BVALID = 1;
        sl_wr++;
        got_aw = 0; got_w = 0;
      end
      bus.AWREADY = bus.AWVALID && !got_aw && (aw_wait >= cfg_awd);
      if (bus.AWVALID && !bus.AWREADY) aw_wait++;
      bus.WREADY  = bus.WVALID && !got_w;
      bus.ARREADY = bus.ARVALID;
      aw_hs = bus.AWVALID && bus.AWREADY;
      if (aw_hs) begin a_aw = bus.AWADDR; aw_wait = 0; end
      w_hs = bus.WVALID && bus.WREADY;
      if (w_hs) d_w = bus.WDATA;
      ar_hs = bus.ARVALID && bus.ARREADY;
      if (ar_hs) a_ar = bus.ARADDR;
      b_hs = bus.BVALID && bus.BREADY;
      r_hs = bus.RVALID && bus.RREADY;
    end
  end

  // Compare process: every cycle, just before the next rising edge.
  initial begin
    bit pv_aw, pv_w;
    logic [31:0] pa_aw, pd_w;
    pv_aw = 0; pv_w = 0; pa_aw = 0; pd_w = 0;
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESETN) begin pv_aw = 0; pv_w = 0; continue; end
      if (pv_aw) begin
        check("awvalid_hold", 64'(bus.AWVALID), 64'd1);
        check("awaddr_hold", 64'(bus.AWADDR), 64'(pa_aw));
      end
      if (pv_w) begin
        check("wvalid_hold", 64'(bus.WVALID), 64'd1);
        check("wdata_hold", 64'(bus.WDATA), 64'(pd_w));
      end
      if (bus.AWVALID && bus.AWREADY) begin
        check("awaddr", 64'(bus.AWADDR), 64'(m_addr(aw_n)));
        aw_log.push_back(bus.AWADDR);
        aw_n++;
      end
      if (bus.WVALID && bus.WREADY) begin
        check("wdata", 64'(bus.WDATA), 64'(m_pat(w_n)));
        check("wstrb", 64'(bus.WSTRB), 64'hF);
        w_n++;
      end
      if (bus.ARVALID && bus.ARREADY) begin
        check("araddr", 64'(bus.ARADDR), 64'(m_addr(ar_n)));
        ar_n++;
      end
      if (bus.BVALID && bus.BREADY) b_n++;
      if (bus.RVALID && bus.RREADY) r_n++;
      if (bus.AWVALID && !bus.WVALID) seen_w_first = 1;
      check("busy_and_done", 64'(busy & done), 64'd0);
      if (done) begin
        check("err_count", 64'(err_count), 64'(exp_err));
        check("pass", 64'(pass), 64'(exp_err == 0));
      end else begin
        check("pass_idle", 64'(pass), 64'd0);
      end
      pv_aw = bus.AWVALID && !bus.AWREADY; pa_aw = bus.AWADDR;
      pv_w  = bus.WVALID && !bus.WREADY;   pd_w  = bus.WDATA;
    end
  end

  task automatic start_run(input int bwr, input int brd, input int brr, input int awd);
    start = 1;
    @(posedge ACLK);
    #1;
    start = 0;
    cfg_bwr = bwr; cfg_brd = brd; cfg_brr = brr; cfg_awd = awd;
    sl_wr = 0; sl_rd = 0;
    aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
    aw_log.delete();
    seen_w_first = 0;
    exp_err = 0;
    for (int i = 0; i < NW; i++) begin
      if (i == bwr) exp_err++;
      if (i == brd || i == brr) exp_err++;
    end
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_clr", 64'(done), 64'd0);
    check("start_err_clr", 64'(err_count), 64'd0);
  endtask

  task automatic wait_done(input int mid, output int cyc);
    bit fin;
    fin = 0;
    cyc = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge ACLK);
      #2;
      start = (c == mid);
      if (busy) cyc++;
      if (done) fin = 1;
    end
    start = 0;
    check("run_finished", 64'(fin), 64'd1);
    check("writes_b", 64'(b_n), 64'(NW));
    check("reads_r", 64'(r_n), 64'(NW));
  endtask

  task automatic check_mem();
    for (int i = 0; i < NW; i++)
      check("mem_word", 64'(mem.exists(m_addr(i)) ? mem[m_addr(i)] : 32'hDEAD_BEEF),
            64'(m_pat(i)));
  endtask

  initial begin
    logic [31:0] lit_addr [NW];
    int cyc;
    bit ok;
    lit_addr[0] = 32'hFFFF_FFF8; lit_addr[1] = 32'hFFFF_FFFC;
    lit_addr[2] = 32'h0000_0000; lit_addr[3] = 32'h0000_0004;

    @(posedge ACLK); #1;
    check("rst_ctrl", 64'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY,
                           busy, done, pass}), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_addr_data", 64'({bus.AWADDR | bus.ARADDR | bus.WDATA}), 64'd0);
    @(posedge ACLK); #1;
    ARESETN = 1;
    repeat (3) @(posedge ACLK);
    #1;
    check("idle_no_start", 64'({busy, done, bus.AWVALID}), 64'd0);

    // ideal slave
    start_run(-1, -1, -1, 0);
    wait_done(-1, cyc);
    check("ideal_busy_cycles", 64'(cyc), 64'd16);
    check("ideal_pass", 64'(pass), 64'd1);
    check("ideal_err", 64'(err_count), 64'd0);
    for (int i = 0; i < NW; i++) check("wrap_addr", 64'(aw_log.size() > i ? aw_log[i] : 32'h1), 64'(lit_addr[i]));
    check("mem_word2_literal", 64'(mem.exists(32'h0) ? mem[32'h0] : 32'h1), 64'hA5A5_0002);
    check_mem();

    // AWREADY held off 3 cycles, WREADY immediate
    start_run(-1, -1, -1, 3);
    wait_done(-1, cyc);
    check("awdly_busy_cycles", 64'(cyc), 64'd28);
    check("awdly_w_first", 64'(seen_w_first), 64'd1);
    check("awdly_pass", 64'(pass), 64'd1);
    check_mem();

    // SLVERR on write 1, bit flip on read 2
    start_run(1, 2, -1, 0);
    wait_done(-1, cyc);
    check("fault_err_literal", 64'(err_count), 64'd2);
    check("fault_pass", 64'(pass), 64'd0);

    // read 0 fails both data and response (counts once) plus SLVERR on write 3
    start_run(3, 0, 0, 0);
    wait_done(-1, cyc);
    check("dbl_err_literal", 64'(err_count), 64'd2);

    // restart after a failing run, with a start pulse mid-run that must be ignored
    start_run(-1, -1, -1, 0);
    wait_done(5, cyc);
    check("restart_busy_cycles", 64'(cyc), 64'd16);
    check("restart_pass", 64'(pass), 64'd1);
    for (int i = 0; i < NW; i++) check("restart_addr", 64'(aw_log.size() > i ? aw_log[i] : 32'h1), 64'(lit_addr[i]));

    // reset asserted while a read response is awaited
    start_run(-1, -1, -1, 0);
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge ACLK);
      #2;
      if (bus.RREADY) ok = 1;
    end
    check("reach_rd_resp", 64'(ok), 64'd1);
    ARESETN = 0;
    #1;
    check("abort_ctrl", 64'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY,
                             busy, done, pass}), 64'd0);
    check("abort_err", 64'(err_count), 64'd0);
    check("abort_addr_data", 64'({bus.AWADDR | bus.ARADDR | bus.WDATA}), 64'd0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      #2;
      check("post_abort_idle", 64'({busy, done, bus.AWVALID, bus.ARVALID}), 64'd0);
    end
    start_run(-1, -1, -1, 0);
    wait_done(-1, cyc);
    check("post_abort_pass", 64'(pass), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
